idea_iter_engine: RTL and testbench
===================================

// Module: idea_iter_engine
// PURPOSE
//  Iterative IDEA encryption core. Processes one 64-bit block per job with a single
//  round datapath reused for ROUNDS clock cycles, then applies the output transformation.
//  The 128-bit key is expanded on chip. Sits between the block framer and the
//  ciphertext FIFO, with valid/ready handshakes on both sides.
// PARAMETERS
//  ROUNDS   8   full rounds per block, legal range 1..8; 8 gives standard IDEA
//  NSUB     6*ROUNDS+4   local parameter: number of 16-bit subkeys (52 when ROUNDS=8)
// PORTS
//  clk        in   1    clock; all state updates on the rising edge
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    block and key offered on this cycle
//  in_ready   out  1    engine can accept a job (state IDLE)
//  in_block   in   64   plaintext; X1=[63:48] .. X4=[15:0]
//  in_key     in   128  key; Z1=[127:112] .. Z8=[15:0]
//  out_valid  out  1    ciphertext held on out_block
//  out_ready  in   1    consumer accepts the ciphertext
//  out_block  out  64   ciphertext; Y1=[63:48] .. Y4=[15:0]
//  round_idx  out  4    current round, 0-based; used for debug and coverage
// BEHAVIOUR
//  Reset, asynchronous, active low: state=IDLE, in_ready=1, out_valid=0, out_block=0,
//   round_idx=0, all data and subkey registers cleared.
//  Subkeys: subkey i (0..NSUB-1) = bits [127-16*(i%8) -: 16] of the key rotated
//   left by 25*(i/8). All NSUB subkeys are registered at accept and held until the job ends.
//  Arithmetic:
//   - add is mod 2^16.
//   - mul is mod 2^16+1, with operand 0x0000 meaning 2^16 and result 2^16 encoded as 0x0000.
//   - xor is 16-bit.
//  Round r (subkeys K1..K6 = subkeys 6r .. 6r+5):
//   s1=X1*K1  s2=X2+K2  s3=X3+K3  s4=X4*K4  s5=s1^s3  s6=s2^s4
//   s7=s5*K5  s8=s6+s7  s9=s8*K6  s10=s7+s9
//   next state {X1,X2,X3,X4} = {s1^s9, s3^s9, s2^s10, s4^s10}; middle words are swapped.
//  Output transform (subkeys 6R..6R+3, where R=ROUNDS): undoes the last swap.
//   Y1=X1*K1  Y2=X3+K2  Y3=X2+K3  Y4=X4*K4
//  FSM:
//   IDLE  : in_ready=1. On in_valid, latch block and subkeys, round_idx=0, go ROUND.
//   ROUND : one round per clock. round_idx increments each clock.
//           After round ROUNDS-1, go FINAL.
//   FINAL : compute output transform, register out_block, out_valid=1, go DONE.
//   DONE  : hold out_block and out_valid until out_ready=1, then go IDLE.
//           in_ready is 0 in this state, so no bypass.
//  Latency: accept edge E0, then out_valid=1 from edge E0+ROUNDS+1.
//   Throughput is one block per ROUNDS+3 cycles minimum.
//  Boundaries:
//   - in_valid while busy is ignored; inputs are not sampled outside IDLE.
//   - out_ready held 1 in DONE: 1-cycle out_valid pulse, IDLE on the next edge.
//   - in_block/in_key changing after accept has no effect.
//   - rst_n low mid-job aborts immediately: no out_valid, reset values as above.
//   - round_idx saturates at ROUNDS-1 in FINAL/DONE and returns to 0 in IDLE.
// TESTING
//  1. ROUNDS=8, key 0001_0002_0003_0004_0005_0006_0007_0008,
//     pt 0000_0001_0002_0003 -> ct 11FB_ED2B_0198_6DE5;
//     out_valid exactly 9 edges after accept.
//  2. mul unit: 0000*0000 -> 0001; 0000*0001 -> 0000; FFFF*FFFF -> 0004; 0001*x -> x.
//  3. Backpressure: hold out_ready=0 for 20 cycles -> out_block/out_valid stable,
//     in_ready=0; second in_valid ignored; release -> exactly one handshake, then IDLE.
//  4. Reset mid-job: assert rst_n=0 at round 4 -> all outputs at reset values
//     asynchronously; new job after release -> correct ct per scenario 1.
//  5. Back-to-back: 100 random key/pt jobs with random out_ready -> all ct match the
//     C reference model; ROUNDS=1 and ROUNDS=4 builds -> match model, latency ROUNDS+1.

Source files
------------

// File: rtl/idea_iter_engine_if.sv
// Valid/ready job interface of the iterative IDEA engine: the producer offers a
// plaintext block and key, the consumer takes the ciphertext.
interface idea_if;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_block;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_block;
  logic [3:0]   round_idx;

  modport master (
    output in_valid, in_block, in_key, out_ready,
    input  in_ready, out_valid, out_block, round_idx
  );

  modport slave (
    input  in_valid, in_block, in_key, out_ready,
    output in_ready, out_valid, out_block, round_idx
  );
endinterface

// File: rtl/idea_iter_engine.sv
// Iterative IDEA encryption core: one round datapath reused ROUNDS times per block,
// followed by the output transformation; the key schedule is expanded on accept.
module idea_iter_engine #(
  parameter int unsigned ROUNDS = 8
) (
  input  logic  clk,
  input  logic  rst_n,
  idea_if.slave bus
);

  localparam int unsigned NSUB     = 6 * ROUNDS + 4;
  localparam int unsigned IW       = $clog2(NSUB);
  localparam logic [3:0]  LAST_RND = 4'(ROUNDS - 1);
  localparam logic [IW-1:0] OT_BASE = IW'(6 * ROUNDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    round_q, round_d;
  logic [63:0]   x_q, x_d;
  logic [63:0]   out_block_q, out_block_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;
  logic [15:0]   sk_q [NSUB];
  logic [15:0]   sk_d [NSUB];
  logic          accept_s;
  logic [IW-1:0] base_s;
  logic [95:0]   rk_s;
  logic [63:0]   ot_s;

  // Multiplication modulo 2^16+1; 0x0000 stands for 2^16 on both inputs and output.
  function automatic logic [15:0] mul_f(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] ea;
    logic [16:0] eb;
    logic [33:0] prod;
    ea   = (a == 16'h0000) ? 17'h1_0000 : {1'b0, a};
    eb   = (b == 16'h0000) ? 17'h1_0000 : {1'b0, b};
    prod = {17'd0, ea} * {17'd0, eb};
    return 16'(prod % 34'h1_0001);
  endfunction

  // Subkey idx is word idx%8 of the key rotated left by 25 bits per group of eight.
  function automatic logic [15:0] subkey_f(input logic [127:0] key, input int unsigned idx);
    int unsigned  rot;
    logic [127:0] rk;
    rot = (32'd25 * (idx / 32'd8)) % 32'd128;
    rk  = (key << rot) | (key >> (32'd128 - rot));
    return rk[32'd127 - 32'd16 * (idx % 32'd8) -: 16];
  endfunction

  function automatic logic [63:0] round_f(input logic [63:0] x, input logic [95:0] k);
    logic [15:0] s1, s2, s3, s4, s5, s6, s7, s8, s9, s10;
    s1  = mul_f(x[63:48], k[95:80]);
    s2  = x[47:32] + k[79:64];
    s3  = x[31:16] + k[63:48];
    s4  = mul_f(x[15:0], k[47:32]);
    s5  = s1 ^ s3;
    s6  = s2 ^ s4;
    s7  = mul_f(s5, k[31:16]);
    s8  = s6 + s7;
    s9  = mul_f(s8, k[15:0]);
    s10 = s7 + s9;
    // Middle words leave the round swapped.
    return {s1 ^ s9, s3 ^ s9, s2 ^ s10, s4 ^ s10};
  endfunction

  // Output transformation; reading X3 before X2 undoes the last round's swap.
  function automatic logic [63:0] otrans_f(input logic [63:0] x, input logic [63:0] k);
    return {mul_f(x[63:48], k[63:48]),
            x[31:16] + k[47:32],
            x[47:32] + k[31:16],
            mul_f(x[15:0], k[15:0])};
  endfunction

  assign accept_s = (state_q == IDLE) && bus.in_valid;

  // Gather the six subkeys of the current round and the four output subkeys.
  always_comb begin
    base_s = IW'(32'd6 * {28'd0, round_q});
    rk_s   = {sk_q[base_s],          sk_q[base_s + IW'(1)],
              sk_q[base_s + IW'(2)], sk_q[base_s + IW'(3)],
              sk_q[base_s + IW'(4)], sk_q[base_s + IW'(5)]};
    ot_s   = {sk_q[OT_BASE],          sk_q[OT_BASE + IW'(1)],
              sk_q[OT_BASE + IW'(2)], sk_q[OT_BASE + IW'(3)]};
  end

  // Subkey bank loads the whole schedule on accept and holds it for the job.
  always_comb begin
    for (int unsigned i = 32'd0; i < NSUB; i++) begin
      if (accept_s) begin
        sk_d[i] = subkey_f(bus.in_key, i);
      end else begin
        sk_d[i] = sk_q[i];
      end
    end
  end

  // Job sequencing: next state, round counter and datapath updates.
  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    x_d         = x_q;
    out_block_d = out_block_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        round_d = 4'd0;
        if (accept_s) begin
          x_d     = bus.in_block;
          state_d = ROUND;
        end else begin
          state_d = IDLE;
        end
      end
      ROUND: begin
        x_d = round_f(x_q, rk_s);
        if (round_q == LAST_RND) begin
          state_d = FINAL;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      FINAL: begin
        out_block_d = otrans_f(x_q, ot_s);
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          round_d     = 4'd0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        round_d     = 4'd0;
        out_valid_d = 1'b0;
      end
    endcase
    in_ready_d = (state_d == IDLE);
  end

  // State, datapath, subkey and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      round_q     <= 4'd0;
      x_q         <= 64'd0;
      out_block_q <= 64'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      for (int unsigned i = 32'd0; i < NSUB; i++) begin
        sk_q[i] <= 16'h0000;
      end
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      x_q         <= x_d;
      out_block_q <= out_block_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      for (int unsigned i = 32'd0; i < NSUB; i++) begin
        sk_q[i] <= sk_d[i];
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_block = out_block_q;
  assign bus.round_idx = round_q;

endmodule

// File: tb/tb_idea_iter_engine.sv
// Bench for idea_iter_engine: three builds (ROUNDS 8, 4, 1) checked against a
// plain-arithmetic IDEA model with directed vectors, backpressure, reset and random jobs.
module tb_idea_iter_engine;

  localparam int NI = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [NI];
  logic [63:0]  in_block  [NI];
  logic [127:0] in_key    [NI];
  logic         out_ready [NI];
  logic         in_ready  [NI];
  logic         out_valid [NI];
  logic [63:0]  out_block [NI];
  logic [3:0]   round_idx [NI];

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned R = (g == 0) ? 8 : ((g == 1) ? 4 : 1);
    idea_if bus ();
    assign bus.in_valid  = in_valid[g];
    assign bus.in_block  = in_block[g];
    assign bus.in_key    = in_key[g];
    assign bus.out_ready = out_ready[g];
    assign in_ready[g]   = bus.in_ready;
    assign out_valid[g]  = bus.out_valid;
    assign out_block[g]  = bus.out_block;
    assign round_idx[g]  = bus.round_idx;
    idea_iter_engine #(.ROUNDS(R)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  function automatic int rounds_of(input int k);
    return (k == 0) ? 8 : ((k == 1) ? 4 : 1);
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference multiply: numbers 1..65536 with 0 standing for 65536, product mod 65537.
  function automatic logic [15:0] mulm(input logic [15:0] a, input logic [15:0] b);
    longint unsigned aa, bb, r;
    aa = (a == 16'h0000) ? 64'd65536 : {48'd0, a};
    bb = (b == 16'h0000) ? 64'd65536 : {48'd0, b};
    r  = (aa * bb) % 64'd65537;
    return (r == 64'd65536) ? 16'h0000 : r[15:0];
  endfunction

  // Reference cipher: key schedule as a word stream, rotating the key by 25 after every 8 words.
  function automatic logic [63:0] idea_model(input logic [127:0] key, input logic [63:0] pt, input int rounds);
    logic [15:0]  ks [52];
    logic [127:0] kr;
    logic [15:0]  x1, x2, x3, x4, s1, s2, s3, s4, s7, s9, s10;
    int n;
    kr = key;
    n  = 0;
    while (n < 6 * rounds + 4) begin
      for (int w = 0; w < 8; w++) begin
        if (n < 6 * rounds + 4) begin
          ks[n] = kr[127 - 16 * w -: 16];
          n++;
        end
      end
      kr = {kr[102:0], kr[127:103]};
    end
    {x1, x2, x3, x4} = pt;
    for (int r = 0; r < rounds; r++) begin
      s1  = mulm(x1, ks[6 * r]);
      s2  = x2 + ks[6 * r + 1];
      s3  = x3 + ks[6 * r + 2];
      s4  = mulm(x4, ks[6 * r + 3]);
      s7  = mulm(s1 ^ s3, ks[6 * r + 4]);
      s9  = mulm((s2 ^ s4) + s7, ks[6 * r + 5]);
      s10 = s7 + s9;
      x1  = s1 ^ s9;
      x2  = s3 ^ s9;
      x3  = s2 ^ s10;
      x4  = s4 ^ s10;
    end
    return {mulm(x1, ks[6 * rounds]), x3 + ks[6 * rounds + 1],
            x2 + ks[6 * rounds + 2], mulm(x4, ks[6 * rounds + 3])};
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  // One job on build k: accept, latency and round_idx trace, result, hold, handshake.
  // hold < 0 means random out_ready; noise drives junk in_valid/data while busy.
  task automatic run_job(input int k, input logic [127:0] key, input logic [63:0] pt,
                         input logic [63:0] exp, input int hold, input bit noise);
    int n, r;
    bit rok, stable, hs, orr;
    logic [63:0] seen;
    r = rounds_of(k);
    n = 0;
    while (!in_ready[k] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("ready_before_job", in_ready[k], 1'b1);
    in_valid[k] = 1'b1; in_block[k] = pt; in_key[k] = key; out_ready[k] = 1'b0;
    @(posedge clk); #1;
    in_valid[k] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    in_block[k] = {$urandom, $urandom};
    in_key[k]   = {$urandom, $urandom, $urandom, $urandom};
    rok = (round_idx[k] == 4'd0) && !in_ready[k];
    n = 0;
    while (!out_valid[k] && n < 40) begin
      @(posedge clk); #1; n++;
      if (round_idx[k] != 4'((n < r) ? n : r - 1)) rok = 1'b0;
      if (noise) begin
        in_valid[k] = 1'($urandom_range(0, 1));
        in_block[k] = {$urandom, $urandom};
      end
    end
    check("latency", n, r + 1);
    check("round_idx_trace", rok, 1'b1);
    check("ciphertext", out_block[k], exp);
    seen = out_block[k]; stable = 1'b1; hs = 1'b0; n = 0;
    while (!hs && n < 60) begin
      orr = (hold < 0) ? 1'($urandom_range(0, 1)) : (n >= hold);
      if (n >= 50) orr = 1'b1;
      out_ready[k] = orr;
      if (noise) in_valid[k] = 1'($urandom_range(0, 1));
      @(posedge clk); #1; n++;
      if (orr) hs = 1'b1;
      else if (out_valid[k] !== 1'b1 || out_block[k] !== seen || in_ready[k] !== 1'b0) stable = 1'b0;
    end
    in_valid[k] = 1'b0; out_ready[k] = 1'b0;
    check("hold_stable", stable, 1'b1);
    check("valid_after_hs", out_valid[k], 1'b0);
    check("ready_after_hs", in_ready[k], 1'b1);
  endtask

  typedef struct {
    logic [127:0] key;
    logic [63:0]  pt;
    logic [63:0]  ct;
    int           hold;
  } vec_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] p;
  } mvec_t;

  localparam logic [127:0] KEY1 = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
  localparam logic [63:0]  PT1  = 64'h0000_0001_0002_0003;
  localparam logic [63:0]  CT1  = 64'h11FB_ED2B_0198_6DE5;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t  vecs [5];
    mvec_t mvecs [5];
    logic [127:0] key;
    logic [63:0]  pt;
    int n;
    bit quiet;

    vecs[0] = '{KEY1, PT1, CT1, 0};
    vecs[1] = '{128'd0, 64'd0, idea_model(128'd0, 64'd0, 8), 3};
    vecs[2] = '{{8{16'hFFFF}}, {4{16'hFFFF}}, idea_model({8{16'hFFFF}}, {4{16'hFFFF}}, 8), 1};
    vecs[3] = '{KEY1, 64'd0, idea_model(KEY1, 64'd0, 8), 0};
    vecs[4] = '{128'h2BD6_459F_82C5_B300_952C_4910_4881_FF48, 64'hF129_A660_1EF6_2A47,
                idea_model(128'h2BD6_459F_82C5_B300_952C_4910_4881_FF48, 64'hF129_A660_1EF6_2A47, 8), 5};
    mvecs[0] = '{16'h0000, 16'h0000, 16'h0001};
    mvecs[1] = '{16'h0000, 16'h0001, 16'h0000};
    mvecs[2] = '{16'hFFFF, 16'hFFFF, 16'h0004};
    mvecs[3] = '{16'h0001, 16'h1234, 16'h1234};
    mvecs[4] = '{16'h0001, 16'h0000, 16'h0000};

    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      in_valid[k] = 1'b0; in_block[k] = 64'd0; in_key[k] = 128'd0; out_ready[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check("reset_in_ready", in_ready[k], 1'b1);
      check("reset_out_valid", out_valid[k], 1'b0);
      check("reset_out_block", out_block[k], 64'd0);
      check("reset_round_idx", round_idx[k], 4'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++)
      check("model_mul", mulm(mvecs[i].a, mvecs[i].b), mvecs[i].p);
    check("model_known_vector", idea_model(KEY1, PT1, 8), CT1);

    for (int i = 0; i < 5; i++)
      run_job(0, vecs[i].key, vecs[i].pt, vecs[i].ct, vecs[i].hold, 1'b0);

    // Backpressure with junk in_valid during the hold, then no second job may appear.
    run_job(0, KEY1, 64'h0123_4567_89AB_CDEF, idea_model(KEY1, 64'h0123_4567_89AB_CDEF, 8), 20, 1'b1);
    quiet = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) quiet = 1'b0;
    end
    check("no_second_job", quiet, 1'b1);

    // Reset mid-job at round 4; outputs must drop without a clock edge.
    in_valid[0] = 1'b1; in_block[0] = PT1; in_key[0] = KEY1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_job_round", round_idx[0], 4'd4);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_in_ready", in_ready[0], 1'b1);
    check("async_rst_out_valid", out_valid[0], 1'b0);
    check("async_rst_out_block", out_block[0], 64'd0);
    check("async_rst_round_idx", round_idx[0], 4'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_held_out_valid", out_valid[0], 1'b0);
    rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid[0]) n++;
    end
    check("aborted_job_silent", n, 0);
    run_job(0, KEY1, PT1, CT1, 0, 1'b0);

    // Random jobs on every build with random backpressure and busy-time noise.
    for (int k = 0; k < NI; k++) begin
      for (int j = 0; j < ((k == 0) ? 100 : 40); j++) begin
        key = 128'd0;
        pt  = 64'd0;
        for (int w = 0; w < 8; w++) key = {key[111:0], rnd16()};
        for (int w = 0; w < 4; w++) pt = {pt[47:0], rnd16()};
        run_job(k, key, pt, idea_model(key, pt, rounds_of(k)), -1, 1'b1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
